pipe_reg_skid: RTL and testbench
================================

Name: pipe_reg_skid

Overview:
Parametrised pipeline-stage register for the MIPS-Lite datapath. It extends the plain enable/reset stage register with a valid/ready handshake, a one-entry skid buffer, a stage flush and an occupancy count. It sits between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), so that hazard stalls and branch flushes are handled inside the stage without losing data. Full throughput is one transfer per cycle, with registered in_ready.

Parameters:
WIDTH, 32, bit width of the carried stage payload
RST_VAL, {WIDTH{1'b0}}, value loaded into both data registers on rst or flush

Ports:
clk  input  1  clock; all state changes on posedge clk
rst  input  1  synchronous reset, active-high
en  input  1  stage enable; 0 freezes the stage (stall)
flush  input  1  synchronous flush; discards all held entries
in_valid  input  1  upstream has data on in_data
in_ready  output  1  stage can accept this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  head-entry payload, driven directly from the main register
occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - Priority per edge: rst > flush > en=0 > normal operation.
- Storage: main register (drives out_data) and skid register, each with its own valid bit.
- States:
  - EMPTY (occupancy 0)
  - ONE (main valid only, occupancy 1)
  - TWO (both valid, occupancy 2)
- Decoded outputs:
  - out_valid = (state != EMPTY).
  - in_ready = en & (state != TWO). It is a function of registered state and en only; there is no combinational path from out_ready.
- Fire conditions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready & en.
- Reset (rst=1 at an edge):
  - state <= EMPTY.
  - main and skid <= RST_VAL.
  - After the edge: out_valid=0, occupancy=0, out_data=RST_VAL, in_ready=en.
  - Reset mid-transfer drops all entries; any in_fire in that cycle is ignored.
- flush=1 (rst=0):
  - Same effect as reset regardless of en, in_valid or out_ready.
  - A simultaneous in_fire is discarded.
  - A simultaneous out_fire still counts as consumed downstream; the stage does not re-present that entry.
- en=0 (rst=0, flush=0):
  - All registers hold.
  - in_ready=0 and no out_fire.
  - out_valid and out_data remain visible and stable.
- State transitions (en=1):
  - EMPTY:
    - in_fire -> ONE, main <= in_data.
    - Otherwise hold.
  - ONE:
    - in_fire & out_fire -> ONE, main <= in_data.
    - in_fire only -> TWO, skid <= in_data.
    - out_fire only -> EMPTY; main keeps its value (out_data stale but out_valid=0).
    - Neither -> hold.
  - TWO:
    - in_ready=0.
    - out_fire -> ONE, main <= skid.
    - Otherwise hold.
- Latency and ordering:
  - Latency in_fire -> out_valid is 1 cycle from EMPTY.
  - Order is strictly FIFO; no entry is duplicated or lost except by rst or flush.
- Data integrity: out_data must not change while out_valid=1 and out_fire=0.
- Illegal state: skid valid with main invalid is unreachable and must not be entered.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, in_data=32'hDEADBEEF -> after release out_valid=0, occupancy=0, out_data=0, in_ready=1.
- Streaming: out_ready=1, en=1, push 8'h01..8'h08 on consecutive cycles -> out_data shows each value exactly 1 cycle after acceptance, occupancy stays 1, in_ready stays 1 throughout.
- Backpressure and skid:
  - Push 32'h11, 32'h22 with out_ready=0 -> occupancy=2, in_ready=0, out_data=32'h11 stable.
  - Then set out_ready=1 -> 32'h11 then 32'h22 out on consecutive cycles, occupancy 2->1->0.
- Stall: with occupancy=1 and out_data=32'hA5A5A5A5, hold en=0 for 3 cycles with in_valid=1 and out_ready=1 -> no transfers, in_ready=0, outputs unchanged. After en=1, transfers resume.
- Flush:
  - At occupancy=2, assert flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_data=RST_VAL.
  - The in_data offered in the flush cycle never appears at the output.
- Parameter: instantiate WIDTH=8 with RST_VAL=8'h5A and repeat the reset and backpressure cases -> reset out_data=8'h5A, payloads preserved bit-exact.

Source files
------------

// File: rtl/pipe_reg_skid.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer,
// flush and occupancy count. out_data comes straight from the main register.
module pipe_reg_skid #(
  parameter int              WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Encoding doubles as the occupancy count; skid-valid-without-main is not encodable.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             in_fire, out_fire;

  // in_ready depends only on registered state and en, never on out_ready.
  assign in_ready  = en & (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & en;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt = ONE;
          main_nxt  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_nxt = in_data;
        end else if (in_fire) begin
          state_nxt = TWO;
          skid_nxt  = in_data;
        end else if (out_fire) begin
          // main keeps its stale value; out_valid drops
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_nxt = ONE;
          main_nxt  = skid_q;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Flush matches reset: drops held entries and any same-cycle input.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= EMPTY;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid: a 32-bit default instance and an 8-bit
// instance with a non-zero reset value, sharing one clock.
module tb_pipe_reg_skid;

  logic clk;
  int   errors;
  int   checks;

  logic        rst, en, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;

  logic        b_rst, b_en, b_flush, b_in_valid, b_out_ready;
  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_in_data, b_out_data;
  logic [1:0]  b_occupancy;

  pipe_reg_skid dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_reg_skid #(.WIDTH(8), .RST_VAL(8'h5A)) dut8 (
    .clk(clk), .rst(b_rst), .en(b_en), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then settle before checking or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; flush = 0; in_valid = 1; in_data = 32'hDEADBEEF; out_ready = 0;
    step(); step();
    rst = 0; in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_streaming();
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_data = 32'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got=%0b exp=1", i, in_ready); end
      step();
      checks++; if (out_data !== 32'(i)) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, i); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
    end
    in_valid = 0;
    step();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain_occ got=%0d exp=0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h8) begin errors++; $display("FAIL stream_stale_data got=%h exp=8", out_data); end
    out_ready = 0;
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; in_data = 32'h11;
    step();
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ1 got=%0d exp=1", occupancy); end
    in_data = 32'h22;
    step();
    in_valid = 0; in_data = 32'hBAD0BAD0;
    #1;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ2 got=%0d exp=2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_data !== 32'h11) begin errors++; $display("FAIL bp_head got=%h exp=11", out_data); end
    step();
    checks++; if (out_data !== 32'h11) begin errors++; $display("FAIL bp_head_stable got=%h exp=11", out_data); end
    out_ready = 1;
    step();
    checks++; if (out_data !== 32'h22) begin errors++; $display("FAIL bp_second got=%h exp=22", out_data); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ_after1 got=%0d exp=1", occupancy); end
    step();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL bp_occ_after2 got=%0d exp=0", occupancy); end
    out_ready = 0;
  endtask

  task automatic test_stall();
    in_valid = 1; in_data = 32'hA5A5A5A5; out_ready = 0;
    step();
    en = 0; in_valid = 1; in_data = 32'h12345678; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got=%0b exp=0", i, in_ready); end
      step();
      checks++; if (out_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL stall_data[%0d] got=%h exp=a5a5a5a5", i, out_data); end
      checks++; if (occupancy !== 2'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_occ[%0d] got=%0d/%0b exp=1/1", i, occupancy, out_valid); end
    end
    en = 1; in_data = 32'h77;
    step();
    checks++; if (out_data !== 32'h77 || occupancy !== 2'd1) begin errors++; $display("FAIL stall_resume got=%h/%0d exp=77/1", out_data, occupancy); end
    in_valid = 0;
    step();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stall_drain got=%0d exp=0", occupancy); end
    out_ready = 0;
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_data = 32'h33;
    step();
    in_data = 32'h44;
    step();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
    flush = 1; in_valid = 1; in_data = 32'h99;
    step();
    flush = 0; in_valid = 0;
    #1;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL flush_data got=%h exp=0", out_data); end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0 || out_data === 32'h99) begin errors++; $display("FAIL flush_leak[%0d] got=%0b/%h exp=0/not99", i, out_valid, out_data); end
    end
    out_ready = 0;
  endtask

  task automatic test_param();
    b_rst = 1; b_en = 1; b_flush = 0; b_in_valid = 1; b_in_data = 8'hC3; b_out_ready = 0;
    step(); step();
    b_rst = 0; b_in_valid = 0;
    #1;
    checks++; if (b_out_data !== 8'h5A) begin errors++; $display("FAIL p8_reset_data got=%h exp=5a", b_out_data); end
    checks++; if (b_occupancy !== 2'd0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL p8_reset_occ got=%0d/%0b exp=0/0", b_occupancy, b_out_valid); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL p8_reset_in_ready got=%0b exp=1", b_in_ready); end
    b_in_valid = 1; b_in_data = 8'hA7;
    step();
    b_in_data = 8'h3C;
    step();
    b_in_valid = 0;
    #1;
    checks++; if (b_occupancy !== 2'd2 || b_in_ready !== 1'b0) begin errors++; $display("FAIL p8_bp_full got=%0d/%0b exp=2/0", b_occupancy, b_in_ready); end
    checks++; if (b_out_data !== 8'hA7) begin errors++; $display("FAIL p8_bp_head got=%h exp=a7", b_out_data); end
    b_out_ready = 1;
    step();
    checks++; if (b_out_data !== 8'h3C || b_occupancy !== 2'd1) begin errors++; $display("FAIL p8_bp_second got=%h/%0d exp=3c/1", b_out_data, b_occupancy); end
    step();
    checks++; if (b_occupancy !== 2'd0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL p8_bp_drain got=%0d/%0b exp=0/0", b_occupancy, b_out_valid); end
    b_out_ready = 0;
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1; en = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    b_rst = 1; b_en = 1; b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall();
    test_flush();
    test_param();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
